cov_predict: RTL

- EKF covariance prediction stage. It sits directly downstream of the state-update/Jacobian stage and consumes its packed 4x4 Jacobian F.
- Computes P_pred = F·P·Fᵀ + Qn, with Qn diagonal and constant.
- Uses one time-multiplexed Q-format multiply-accumulate, so the result takes 128 MAC cycles per start.
- State order: 0 = ialpha, 1 = ibeta, 2 = omega, 3 = theta.

---
 rtl/ekf_pkg.sv | 60 ++++++
 rtl/qmac.sv | 54 +++++
 rtl/cov_predict.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ekf_pkg.sv
// Shared definitions for the EKF covariance prediction slice.
// Holds the Q-format word size, the 4x4 matrix element index, the default
// process-noise values with their fixed-point scaling, the state-index names,
// and the saturating narrowing function used by the MAC output.
package ekf_pkg;

    localparam int N     = 32;           // word width, signed
    localparam int Q     = 18;           // fractional bits
    localparam int SF    = 1 << Q;       // fixed-point scale factor
    localparam int PW    = 2 * N;        // full product width
    localparam int ACC_W = 2 * N + 3;    // accumulator width (four products plus headroom)

    localparam int I_ALPHA = 0;
    localparam int I_BETA  = 1;
    localparam int OMEGA   = 2;
    localparam int THETA   = 3;

    localparam real QN_I_DEF     = 0.1;
    localparam real QN_OMEGA_DEF = 1.0;
    localparam real QN_THETA_DEF = 0.001;

    typedef logic signed [N-1:0] word_t;

    typedef struct packed {
        logic  ovf;
        word_t val;
    } sat_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PH1  = 2'd1,
        S_PH2  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    // Element (r,c) of a packed 4x4 matrix lives in word 4r+c.
    function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

    // Real noise value to Q-format integer, truncated toward zero.
    function automatic word_t qn_scale(input real x);
        return word_t'($rtoi(x * real'(SF)));
    endfunction

    // Narrow to N bits with clamping; the value fits only when every bit
    // from N-1 upward equals the sign bit.
    function automatic sat_t sat_n(input logic signed [ACC_W-1:0] x);
        sat_t s;
        if ((x[ACC_W-1:N-1] == '0) || (x[ACC_W-1:N-1] == '1)) begin
            s.ovf = 1'b0;
            s.val = x[N-1:0];
        end else begin
            s.ovf = 1'b1;
            s.val = x[ACC_W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
        return s;
    endfunction

endpackage

// File: rtl/qmac.sv
// Time-multiplexed Q-format multiply-accumulate.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   en_i            accumulate a_i*b_i this cycle
//   last_i          final term of a dot product: accumulator clears after it
//   a_i, b_i        signed N-bit operands
//   qn_i            value added after the fractional shift (diagonal noise)
//   res_o           sat_N(((acc + a*b) >>> Q) + qn), valid while last_i is high
//   sat_o           res_o was clamped
module qmac
    import ekf_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  en_i,
    input  logic  last_i,
    input  word_t a_i,
    input  word_t b_i,
    input  word_t qn_i,
    output word_t res_o,
    output logic  sat_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] scaled;
    sat_t                    sat_res;

    assign prod    = PW'(a_i) * PW'(b_i);
    assign sum     = acc_q + ACC_W'(prod);
    // Arithmetic shift floors toward -inf before the noise term is added.
    assign scaled  = (sum >>> Q) + ACC_W'(qn_i);
    assign sat_res = sat_n(scaled);
    assign res_o   = sat_res.val;
    assign sat_o   = sat_res.ovf;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = last_i ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cov_predict.sv
// EKF covariance prediction: P_pred = F*P*F^T + diag(qn), one shared MAC.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   start       single-cycle request, accepted only in IDLE
//   F, P        packed 4x4 Jacobian and prior covariance, word 4r+c = (r,c)
//   P_pred      packed predicted covariance, written element by element
//   busy        high while a run is in progress
//   done        one-cycle pulse after the last element is written
//   ovf         sticky saturation flag for the current run
//
// state  | meaning
// IDLE   | waiting for start; F and P are snapshotted on acceptance
// PH1    | T = F*P, one product per cycle, 64 cycles
// PH2    | P_pred = T*F^T + diag(qn), 64 cycles
// FIN    | drops busy and pulses done on the way back to IDLE
module cov_predict
    import ekf_pkg::*;
#(
    parameter real QN_I     = QN_I_DEF,
    parameter real QN_OMEGA = QN_OMEGA_DEF,
    parameter real QN_THETA = QN_THETA_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [16*N-1:0] F,
    input  logic [16*N-1:0] P,
    output logic [16*N-1:0] P_pred,
    output logic            busy,
    output logic            done,
    output logic            ovf
);

    localparam word_t QN_I_S     = qn_scale(QN_I);
    localparam word_t QN_OMEGA_S = qn_scale(QN_OMEGA);
    localparam word_t QN_THETA_S = qn_scale(QN_THETA);

    // ialpha and ibeta share the same noise value.
    function automatic word_t qn_of(input logic [1:0] r);
        if (r == 2'(OMEGA)) begin
            return QN_OMEGA_S;
        end else if (r == 2'(THETA)) begin
            return QN_THETA_S;
        end
        return QN_I_S;
    endfunction

    state_e     state_q;
    logic [1:0] r_q;
    logic [1:0] c_q;
    logic [1:0] k_q;
    word_t      f_q  [16];
    word_t      p_q  [16];
    word_t      t_q  [16];
    word_t      pp_q [16];
    logic       busy_q;
    logic       done_q;
    logic       ovf_q;

    word_t      mac_a;
    word_t      mac_b;
    word_t      mac_qn;
    logic       mac_en;
    logic       mac_last;
    word_t      mac_res;
    logic       mac_sat;

    // F^T in PH2 comes from swapping the index order into the stored F.
    always_comb begin
        mac_a  = '0;
        mac_b  = '0;
        mac_qn = '0;
        mac_en = 1'b0;
        case (state_q)
            S_PH1: begin
                mac_en = 1'b1;
                mac_a  = f_q[idx(r_q, k_q)];
                mac_b  = p_q[idx(k_q, c_q)];
            end
            S_PH2: begin
                mac_en = 1'b1;
                mac_a  = t_q[idx(r_q, k_q)];
                mac_b  = f_q[idx(c_q, k_q)];
                mac_qn = (r_q == c_q) ? qn_of(r_q) : '0;
            end
            default: ;
        endcase
    end

    assign mac_last = (k_q == 2'd3);

    qmac u_qmac (
        .clk    (clk),
        .reset  (reset),
        .en_i   (mac_en),
        .last_i (mac_last),
        .a_i    (mac_a),
        .b_i    (mac_b),
        .qn_i   (mac_qn),
        .res_o  (mac_res),
        .sat_o  (mac_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                f_q[i]  <= '0;
                p_q[i]  <= '0;
                t_q[i]  <= '0;
                pp_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            f_q[i] <= F[i*N +: N];
                            p_q[i] <= P[i*N +: N];
                        end
                        r_q     <= '0;
                        c_q     <= '0;
                        k_q     <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_PH1;
                    end
                end
                S_PH1, S_PH2: begin
                    k_q <= k_q + 2'd1;
                    if (mac_last) begin
                        if (state_q == S_PH1) begin
                            t_q[idx(r_q, c_q)] <= mac_res;
                        end else begin
                            pp_q[idx(r_q, c_q)] <= mac_res;
                        end
                        if (mac_sat) begin
                            ovf_q <= 1'b1;
                        end
                        c_q <= c_q + 2'd1;
                        if (c_q == 2'd3) begin
                            r_q <= r_q + 2'd1;
                            if (r_q == 2'd3) begin
                                state_q <= (state_q == S_PH1) ? S_PH2 : S_FIN;
                            end
                        end
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        P_pred = '0;
        for (int i = 0; i < 16; i++) begin
            P_pred[i*N +: N] = pp_q[i];
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule
